// File: rtl/reg_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bus_pkg
//  Description : Shared types for the register bus: bus opcode encoding,
//                requester FSM states and the legal-command check.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_bus_pkg;

  // Bus opcode; the same encoding is used on the command channel.
  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_RD  = 2'b01,
    OP_WR  = 2'b10
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ISSUE   = 2'b01,
    S_WAIT_RD = 2'b10,
    S_RESP    = 2'b11
  } state_t;

  // Bit n set means command opcode n is legal (RD and WR only).
  localparam logic [3:0] LEGAL_OP_MASK = 4'b0110;

  function automatic logic op_is_legal(input logic [1:0] op);
    return LEGAL_OP_MASK[op];
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bus_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bus_if
//  Description : Register bus. The requester drives op/addr/wdata; the
//                responder returns rdata a fixed number of cycles later.
//  Ports       : op, addr, wdata (req -> rsp), rdata (rsp -> req)
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_bus_if
  import reg_bus_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8
) ();

  op_t               op;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] wdata;
  logic [DWIDTH-1:0] rdata;

  modport req (output op, output addr, output wdata, input rdata);
  modport rsp (input op, input addr, input wdata, output rdata);

endinterface
`default_nettype wire

// File: rtl/reg_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bus_master
//  Description : Register bus requester. Takes one command at a time from a
//                valid/ready channel, runs one bus transaction for it and
//                returns exactly one response on a valid/ready channel.
//  Ports       : clk, rst (async, active low)
//                cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_wdata - command in
//                resp_valid/resp_ready/resp_rdata/resp_is_rd/resp_err
//                                                     - response out
//                bus - reg_bus_if requester side
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DWIDTH-1:0] resp_rdata,
  output logic              resp_is_rd,
  output logic              resp_err,
  reg_bus_if.req            bus
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  state_t            state_q,      state_d;
  op_t               bus_op_q,     bus_op_d;
  logic [AWIDTH-1:0] bus_addr_q,   bus_addr_d;
  logic [DWIDTH-1:0] bus_wdata_q,  bus_wdata_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DWIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_is_rd_q, resp_is_rd_d;
  logic              resp_err_q,   resp_err_d;

  // Next-state and output logic. bus op defaults to NOP so it is only
  // non-NOP during the single ISSUE cycle; addr/wdata hold their values.
  always_comb begin
    state_d      = state_q;
    bus_op_d     = OP_NOP;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_is_rd_d = resp_is_rd_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (op_is_legal(cmd_op)) begin
            // Registering the command straight onto the bus makes the
            // ISSUE cycle the one right after the handshake.
            bus_op_d    = op_t'(cmd_op);
            bus_addr_d  = cmd_addr;
            bus_wdata_d = cmd_wdata;
            state_d     = S_ISSUE;
          end else begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_is_rd_d = 1'b0;
            resp_rdata_d = '0;
            state_d      = S_RESP;
          end
        end
      end

      S_ISSUE: begin
        // bus_op_q still holds the latched command op in this cycle.
        if (bus_op_q == OP_RD) begin
          cnt_d   = CNT_W'(RD_LAT - 1);
          state_d = S_WAIT_RD;
        end else begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_is_rd_d = 1'b0;
          resp_rdata_d = '0;
          state_d      = S_RESP;
        end
      end

      S_WAIT_RD: begin
        if (cnt_q == '0) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_is_rd_d = 1'b1;
          resp_rdata_d = bus.rdata;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      bus_op_q     <= OP_NOP;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_is_rd_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_op_q     <= bus_op_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_is_rd_q <= resp_is_rd_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // The only combinational output: ready while idle, forced low in reset.
  assign cmd_ready  = (state_q == S_IDLE) && rst;

  assign bus.op     = bus_op_q;
  assign bus.addr   = bus_addr_q;
  assign bus.wdata  = bus_wdata_q;

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_is_rd = resp_is_rd_q;
  assign resp_err   = resp_err_q;

endmodule
`default_nettype wire
